// File: rtl/prei_mode_buf_pkg.sv
// Shared sizing for the pre-intra mode-map buffer.
package prei_mode_buf_pkg;
    localparam int MODE_W      = 6;
    localparam int MODE_ADDR_W = 7;
    localparam int MODE_DEPTH  = 128;

    // Number of CTU slots in the ping-pong buffer.
    localparam logic [1:0] CTU_SLOTS = 2'd2;
endpackage

// File: rtl/prei_mode_buf_if.sv
// Mode-RAM write side and CTU handshake/read side of the mode buffer.
interface prei_mode_buf_if
    import prei_mode_buf_pkg::*;
#(
    parameter int DATA_W = MODE_W,
    parameter int ADDR_W = MODE_ADDR_W
);
    logic              md_we;
    logic [ADDR_W-1:0] md_waddr;
    logic [DATA_W-1:0] md_wdata;
    logic              wr_start_i;
    logic              wr_done_i;
    logic              wr_ready_o;
    logic              rd_start_i;
    logic              rd_done_i;
    logic              rd_ready_o;
    logic              rd_en_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o;
    logic              err_o;

    modport master (
        output md_we, md_waddr, md_wdata, wr_start_i, wr_done_i,
        output rd_start_i, rd_done_i, rd_en_i, rd_addr_i,
        input  wr_ready_o, rd_ready_o, rd_data_o, rd_valid_o, err_o
    );

    modport slave (
        input  md_we, md_waddr, md_wdata, wr_start_i, wr_done_i,
        input  rd_start_i, rd_done_i, rd_en_i, rd_addr_i,
        output wr_ready_o, rd_ready_o, rd_data_o, rd_valid_o, err_o
    );
endinterface

// File: rtl/prei_mode_ram_2p.sv
// One mode-map bank: one write port, one registered read port that holds when idle.
module prei_mode_ram_2p #(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem_q[raddr];
    end

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rstn) rdata_q <= '0;
        else      rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/prei_mode_buf.sv
// Ping-pong buffer for one CTU of best-mode map between pre-intra and the encoder.
//   state  | meaning
//   W_IDLE | writer holds no bank
//   W_FILL | writer owns bank wr_ptr and accepts md_we
//   R_IDLE | reader holds no bank
//   R_READ | reader owns bank rd_ptr and accepts rd_en_i
module prei_mode_buf
    import prei_mode_buf_pkg::*;
#(
    parameter int DATA_W = MODE_W,
    parameter int ADDR_W = MODE_ADDR_W,
    parameter int DEPTH  = MODE_DEPTH
) (
    input  logic           clk,
    input  logic           rstn,
    prei_mode_buf_if.slave bus
);
    localparam logic W_IDLE = 1'b0;
    localparam logic W_FILL = 1'b1;
    localparam logic R_IDLE = 1'b0;
    localparam logic R_READ = 1'b1;

    logic       wr_state_q, wr_state_d;
    logic       rd_state_q, rd_state_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       err_q, err_d;
    logic       rd_valid_q, rd_valid_d;
    logic       rd_sel_q, rd_sel_d;

    logic       wr_ready, rd_ready, wr_commit, rd_release, rd_fire;
    logic [1:0] bank_we, bank_re;
    logic [DATA_W-1:0] bank_rdata [2];

    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_sel_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_sel_q   <= rd_sel_d;
        end
    end

    always_comb begin
        wr_ready   = (count_q < CTU_SLOTS) && (wr_state_q == W_IDLE);
        rd_ready   = (count_q != 2'd0) && (rd_state_q == R_IDLE);
        wr_commit  = (wr_state_q == W_FILL) && bus.wr_done_i;
        rd_release = (rd_state_q == R_READ) && bus.rd_done_i;
        rd_fire    = (rd_state_q == R_READ) && bus.rd_en_i;
    end

    always_comb begin
        wr_state_d = wr_state_q;
        rd_state_d = rd_state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (wr_commit) begin
            wr_state_d = W_IDLE;
            wr_ptr_d   = ~wr_ptr_q;
        end else if (bus.wr_start_i && wr_ready) begin
            wr_state_d = W_FILL;
        end
        if (rd_release) begin
            rd_state_d = R_IDLE;
            rd_ptr_d   = ~rd_ptr_q;
        end else if (bus.rd_start_i && rd_ready) begin
            rd_state_d = R_READ;
        end
        // Commit and release in the same cycle cancel out.
        count_d = count_q + {1'b0, wr_commit} - {1'b0, rd_release};
        err_d   = err_q
                | (bus.wr_start_i && !wr_ready)
                | (bus.md_we && (wr_state_q == W_IDLE))
                | (bus.wr_done_i && (wr_state_q == W_IDLE))
                | (bus.rd_start_i && !rd_ready)
                | (bus.rd_done_i && (rd_state_q == R_IDLE));
        rd_valid_d = rd_fire;
        rd_sel_d   = rd_fire ? rd_ptr_q : rd_sel_q;
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_we[b] = bus.md_we && (wr_state_q == W_FILL) && (wr_ptr_q == 1'(b));
            bank_re[b] = rd_fire && (rd_ptr_q == 1'(b));
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        prei_mode_ram_2p #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_ram (
            .clk   (clk),
            .rstn  (rstn),
            .we    (bank_we[b]),
            .waddr (bus.md_waddr),
            .wdata (bus.md_wdata),
            .re    (bank_re[b]),
            .raddr (bus.rd_addr_i),
            .rdata (bank_rdata[b])
        );
    end

    assign bus.wr_ready_o = wr_ready;
    assign bus.rd_ready_o = rd_ready;
    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_data_o  = bank_rdata[rd_sel_q];
    assign bus.err_o      = err_q;
endmodule

// File: tb/tb_prei_mode_buf.sv
// Directed and randomized bench for prei_mode_buf against a CTU-level reference model.
module tb_prei_mode_buf;
    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    prei_mode_buf_if bus ();
    prei_mode_buf dut (.clk(clk), .rstn(rstn), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Reference model: two CTU slots, which slot each side owns, how many are committed.
    logic [5:0] m_mem [2][128];
    int   m_cnt;
    bit   m_fill, m_read, m_wb, m_rb, m_err, m_vld;
    logic [5:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_in();
        bus.md_we = 0; bus.wr_start_i = 0; bus.wr_done_i = 0;
        bus.rd_start_i = 0; bus.rd_done_i = 0; bus.rd_en_i = 0;
    endtask

    task automatic model_step();
        bit wr_rdy, rd_rdy, commit, rel;
        if (rstn) begin
            m_cnt = 0; m_fill = 0; m_read = 0; m_wb = 0; m_rb = 0;
            m_err = 0; m_vld = 0; m_data = '0;
            return;
        end
        wr_rdy = (m_cnt < 2) && !m_fill;
        rd_rdy = (m_cnt > 0) && !m_read;
        if ((bus.wr_start_i && !wr_rdy) || (bus.md_we && !m_fill) || (bus.wr_done_i && !m_fill) ||
            (bus.rd_start_i && !rd_rdy) || (bus.rd_done_i && !m_read))
            m_err = 1;
        m_vld = m_read && bus.rd_en_i;
        if (m_vld) m_data = m_mem[m_rb][bus.rd_addr_i];
        if (m_fill && bus.md_we) m_mem[m_wb][bus.md_waddr] = bus.md_wdata;
        commit = m_fill && bus.wr_done_i;
        rel    = m_read && bus.rd_done_i;
        if (commit) begin m_fill = 0; m_wb = !m_wb; m_cnt++; end
        else if (bus.wr_start_i && wr_rdy) m_fill = 1;
        if (rel) begin m_read = 0; m_rb = !m_rb; m_cnt--; end
        else if (bus.rd_start_i && rd_rdy) m_read = 1;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("wr_ready", bus.wr_ready_o, (m_cnt < 2) && !m_fill);
        chk("rd_ready", bus.rd_ready_o, (m_cnt > 0) && !m_read);
        chk("rd_valid", bus.rd_valid_o, m_vld);
        chk("rd_data",  bus.rd_data_o,  m_data);
        chk("err",      bus.err_o,      m_err);
        clear_in();
    endtask

    task automatic do_reset();
        rstn = 1; cycle(); rstn = 0;
    endtask

    // v < 0 writes k%64 at address k, otherwise the constant v everywhere.
    task automatic fill_ctu(input int v);
        bus.wr_start_i = 1; cycle();
        for (int k = 0; k < 128; k++) begin
            bus.md_we = 1; bus.md_waddr = 7'(k);
            bus.md_wdata = (v < 0) ? 6'(k % 64) : 6'(v);
            cycle();
        end
        bus.wr_done_i = 1; cycle();
    endtask

    task automatic read_one(input int a);
        bus.rd_en_i = 1; bus.rd_addr_i = 7'(a); cycle();
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < 128; k++) m_mem[b][k] = '0;
        clear_in();
        bus.md_waddr = '0; bus.md_wdata = '0; bus.rd_addr_i = '0;

        // Single CTU
        do_reset();
        chk("rst_wr_ready", bus.wr_ready_o, 1);
        chk("rst_rd_ready", bus.rd_ready_o, 0);
        fill_ctu(-1);
        bus.rd_start_i = 1; cycle();
        for (int k = 0; k < 128; k++) begin
            read_one(k);
            chk("t1_data", bus.rd_data_o, k % 64);
        end
        bus.rd_done_i = 1; cycle();
        chk("t1_empty", bus.rd_ready_o, 0);

        // Ping-pong full
        do_reset();
        fill_ctu(5);
        fill_ctu(9);
        chk("t2_full", bus.wr_ready_o, 0);
        bus.wr_start_i = 1; cycle();
        chk("t2_err", bus.err_o, 1);
        chk("t2_held", bus.wr_ready_o, 0);
        bus.rd_start_i = 1; cycle();
        read_one(17); chk("t2_a", bus.rd_data_o, 5);
        bus.rd_done_i = 1; cycle();
        bus.rd_start_i = 1; cycle();
        read_one(17); chk("t2_b", bus.rd_data_o, 9);

        // Simultaneous done
        do_reset();
        fill_ctu(20);
        bus.rd_start_i = 1; cycle();
        bus.wr_start_i = 1; cycle();
        for (int k = 0; k < 128; k++) begin
            bus.md_we = 1; bus.md_waddr = 7'(k); bus.md_wdata = 6'd40;
            bus.rd_en_i = 1; bus.rd_addr_i = 7'($urandom_range(127));
            cycle();
        end
        bus.wr_done_i = 1; bus.rd_done_i = 1; cycle();
        chk("t3_rd_ready", bus.rd_ready_o, 1);
        chk("t3_wr_ready", bus.wr_ready_o, 1);
        bus.rd_start_i = 1; cycle();
        read_one(7); chk("t3_data", bus.rd_data_o, 40);

        // Illegal accesses
        do_reset();
        bus.md_we = 1; bus.md_waddr = 7'd3; bus.md_wdata = 6'd63;
        bus.rd_en_i = 1; bus.rd_addr_i = 7'd3; cycle();
        chk("t4_err", bus.err_o, 1);
        chk("t4_valid", bus.rd_valid_o, 0);
        bus.wr_start_i = 1; cycle();
        bus.md_we = 1; bus.md_waddr = 7'd3; bus.md_wdata = 6'd12; cycle();
        bus.wr_done_i = 1; cycle();
        bus.rd_start_i = 1; cycle();
        read_one(3); chk("t4_data", bus.rd_data_o, 12);

        // Reset mid-fill
        do_reset();
        bus.wr_start_i = 1; cycle();
        for (int k = 0; k < 10; k++) begin
            bus.md_we = 1; bus.md_waddr = 7'(k); bus.md_wdata = 6'(k + 1); cycle();
        end
        do_reset();
        chk("t5_wr_ready", bus.wr_ready_o, 1);
        chk("t5_rd_ready", bus.rd_ready_o, 0);
        chk("t5_err", bus.err_o, 0);
        chk("t5_valid", bus.rd_valid_o, 0);
        fill_ctu(-1);
        bus.rd_start_i = 1; cycle();
        read_one(70); chk("t5_data", bus.rd_data_o, 6);

        // Last-cycle write
        do_reset();
        bus.wr_start_i = 1; cycle();
        bus.md_we = 1; bus.md_waddr = 7'd127; bus.md_wdata = 6'd33; bus.wr_done_i = 1; cycle();
        bus.rd_start_i = 1; cycle();
        read_one(127); chk("t6_data", bus.rd_data_o, 33);

        // Randomized traffic, mostly legal with occasional protocol errors and resets
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rstn = ($urandom_range(799) == 0);
            bus.wr_start_i = ($urandom_range(7) == 0);
            bus.wr_done_i  = m_fill ? ($urandom_range(40) == 0) : ($urandom_range(300) == 0);
            bus.md_we      = m_fill ? ($urandom_range(1) == 0) : ($urandom_range(300) == 0);
            bus.md_waddr   = 7'($urandom_range(127));
            bus.md_wdata   = 6'($urandom_range(63));
            bus.rd_start_i = ($urandom_range(7) == 0);
            bus.rd_done_i  = m_read ? ($urandom_range(40) == 0) : ($urandom_range(300) == 0);
            bus.rd_en_i    = ($urandom_range(1) == 0);
            bus.rd_addr_i  = 7'($urandom_range(127));
            cycle();
        end
        rstn = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/prei_mode_buf.md
Name: prei_mode_buf

Overview:
- Receiving end of the pre-intra mode-RAM write interface (md_we/md_waddr/md_wdata).
- Captures the best-mode map written by the mode-decision engine for one CTU into a ping-pong buffer of two banks.
- Serves that map to the downstream intra/encoder stage through a 1-cycle-latency read port.
- CTU-level start/done handshakes on both sides decouple the pre-intra producer from the consumer, so the next CTU's mode decision overlaps encoding of the current CTU.

Parameters:
- DATA_W, 6, mode word width (matches md_wdata)
- ADDR_W, 7, entry address width (matches md_waddr)
- DEPTH, 128, entries per bank (2**ADDR_W)

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-high (codebase port name retained)
- md_we  in  1  write strobe from mode decision
- md_waddr  in  ADDR_W  write address
- md_wdata  in  DATA_W  mode value
- wr_start_i  in  1  producer begins filling a CTU (pulse)
- wr_done_i  in  1  producer commits the CTU (pulse)
- wr_ready_o  out  1  a free bank exists
- rd_start_i  in  1  consumer begins a CTU (pulse)
- rd_done_i  in  1  consumer releases the CTU (pulse)
- rd_ready_o  out  1  a committed bank exists
- rd_en_i  in  1  read request
- rd_addr_i  in  ADDR_W  read address
- rd_data_o  out  DATA_W  read data
- rd_valid_o  out  1  rd_data_o valid this cycle
- err_o  out  1  sticky protocol-error flag

Behaviour:
State and reset:
- State: wr_ptr (1b), rd_ptr (1b), count (0..2), wr_state {W_IDLE, W_FILL}, rd_state {R_IDLE, R_READ}, err.
- Reset: wr_ptr=0, rd_ptr=0, count=0, both FSMs IDLE, rd_data_o=0, rd_valid_o=0, err_o=0.
- Reset forces wr_ready_o=1 and rd_ready_o=0.
- Bank contents are not reset and are not cleared at wr_start.

Ready flags (combinational from count):
- wr_ready_o = (count<2) && wr_state==W_IDLE.
- rd_ready_o = (count>0) && rd_state==R_IDLE.

Write FSM:
- W_IDLE -> W_FILL on wr_start_i && wr_ready_o.
- In W_FILL, md_we writes md_wdata to bank[wr_ptr][md_waddr]. Any address 0..127 is accepted; duplicate writes overwrite (last wins).
- W_FILL -> W_IDLE on wr_done_i. In the same cycle: wr_ptr toggles, count increments. A md_we in that same cycle is still written.

Read FSM:
- R_IDLE -> R_READ on rd_start_i && rd_ready_o.
- In R_READ, rd_en_i registers bank[rd_ptr][rd_addr_i] into rd_data_o next cycle, with rd_valid_o=1 for exactly that cycle.
- Back-to-back reads give one result per cycle.
- rd_en_i outside R_READ: no read, rd_valid_o=0, rd_data_o holds.
- R_READ -> R_IDLE on rd_done_i. In the same cycle: rd_ptr toggles, count decrements.
- A rd_en_i in the rd_done_i cycle is still served.

Simultaneous events and boundaries:
- wr_done_i and rd_done_i in the same cycle: count unchanged, both pointers toggle.
- count never exceeds 2 or goes below 0. Banks are exclusive (writer owns wr_ptr bank, reader owns rd_ptr bank), so no same-bank read/write collision is possible.
- Full (count==2): wr_start_i ignored, err set.
- Empty (count==0): rd_start_i ignored, err set.

Protocol errors (set err, sticky until reset, no state change):
- wr_start_i while not wr_ready_o
- md_we in W_IDLE (write dropped)
- wr_done_i in W_IDLE
- rd_start_i while not rd_ready_o
- rd_done_i in R_IDLE

Reset mid-operation:
- Any FILL in progress is abandoned and all committed CTUs are discarded (count=0).

Decomposition:
- Add to enc_defines.v: MODE_W (6), MODE_ADDR_W (7), MODE_DEPTH (128). No new typedefs; FSM state encodings are local parameters.
- One sub-module, prei_mode_ram_2p: single bank, 1 write port + 1 registered read port, DEPTH x DATA_W. Instantiate twice.
- Bank select, FSMs, count and error logic live in prei_mode_buf.

Test Plan:
- Single CTU: reset; wr_start; write addr k = k%64 for k=0..127; wr_done; rd_start; read 0..127 back-to-back. Required: rd_valid_o one cycle after each rd_en_i, data = k%64, count returns to 0 after rd_done.
- Ping-pong full: fill CTU A (data 5) and CTU B (data 9) without reading. Required: wr_ready_o=0 after second commit; third wr_start sets err_o=1 with count held at 2; reads return 5, then after rd_done return 9.
- Simultaneous done: reader in R_READ on bank 0 while writer fills bank 1; assert wr_done_i and rd_done_i in the same cycle. Required: count stays 1, rd_ptr=1, rd_ready_o=1 next cycle, and the next read returns bank-1 data.
- Illegal accesses: md_we with data 63 in W_IDLE to addr 3, and rd_en_i in R_IDLE. Required: err_o=1, rd_valid_o=0, and a later committed CTU that wrote addr 3 = 12 reads back 12.
- Reset mid-fill: wr_start, 10 writes, assert rstn one cycle. Required: count=0, wr_ready_o=1, rd_ready_o=0, err_o=0, rd_valid_o=0; a subsequent full CTU commits normally.
- Last-cycle write: md_we addr 127 data 33 coincident with wr_done_i. Required: read of addr 127 returns 33.
